// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light phase scheduler.
//   tlc_state_e : scheduler phases with fixed 3-bit codes (also driven on 'phase')
//   tlc_dir_e   : road that was served last (A or B)
//   LAMPS_*     : lamp vectors per phase, ordered {ra,ya,ga,rb,yb,gb,walk}
package tlc_pkg;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    ALLRED   = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    WALK     = 3'd5
  } tlc_state_e;

  typedef enum logic {
    DIR_A = 1'b0,
    DIR_B = 1'b1
  } tlc_dir_e;

  localparam logic [6:0] LAMPS_A_GREEN  = 7'b001_100_0;
  localparam logic [6:0] LAMPS_A_YELLOW = 7'b010_100_0;
  localparam logic [6:0] LAMPS_ALLRED   = 7'b100_100_0;
  localparam logic [6:0] LAMPS_B_GREEN  = 7'b100_001_0;
  localparam logic [6:0] LAMPS_B_YELLOW = 7'b100_010_0;
  localparam logic [6:0] LAMPS_WALK     = 7'b100_100_1;

  function automatic logic [6:0] lamps_of(input tlc_state_e s);
    logic [6:0] l;
    l = LAMPS_ALLRED;
    case (s)
      A_GREEN:  l = LAMPS_A_GREEN;
      A_YELLOW: l = LAMPS_A_YELLOW;
      ALLRED:   l = LAMPS_ALLRED;
      B_GREEN:  l = LAMPS_B_GREEN;
      B_YELLOW: l = LAMPS_B_YELLOW;
      WALK:     l = LAMPS_WALK;
      default:  l = LAMPS_ALLRED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// State-duration counter for the phase scheduler.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart counting from 0 (state change)
//   cmp_val  : value compared against the current count
//   cnt_o    : current count, saturates at MAX_CNT-1
//   cmp_eq   : cnt_o == cmp_val
//   cmp_ge   : cnt_o >= cmp_val
//   at_max   : cnt_o has reached MAX_CNT-1
module tlc_phase_timer #(
  parameter int unsigned MAX_CNT = 10,
  localparam int unsigned CW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] cmp_val,
  output logic [CW-1:0] cnt_o,
  output logic          cmp_eq,
  output logic          cmp_ge,
  output logic          at_max
);

  localparam logic [CW-1:0] CNT_TOP = CW'(MAX_CNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign cmp_eq = (cnt_q == cmp_val);
  assign cmp_ge = (cnt_q >= cmp_val);
  assign at_max = (cnt_q == CNT_TOP);

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Timed phase scheduler for a two-road intersection with a pedestrian phase.
//   clk, rst        : clock, synchronous active-high reset
//   ta, tb          : traffic present on road A / road B
//   ped_req         : pedestrian button (level or pulse)
//   ra,ya,ga        : road A lamps
//   rb,yb,gb        : road B lamps
//   walk            : pedestrian walk lamp
//   ped_pend        : pedestrian request latched, not yet served
//   phase           : current state code
// All outputs decode registered state only.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ta,
  input  logic       tb,
  input  logic       ped_req,
  output logic       ra,
  output logic       ya,
  output logic       ga,
  output logic       rb,
  output logic       yb,
  output logic       gb,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] phase
);

  localparam int unsigned CW = (GREEN_MAX > 1) ? $clog2(GREEN_MAX) : 1;

  tlc_state_e    state_q, state_d;
  tlc_dir_e      last_dir_q, last_dir_d;
  logic          ped_pend_q, ped_pend_d;

  logic [CW-1:0] cmp_val;
  logic [CW-1:0] cnt;
  logic          cmp_eq, cmp_ge, at_max;
  logic          state_chg;

  // One shared comparator: the threshold depends on the current phase.
  always_comb begin
    cmp_val = '0;
    case (state_q)
      A_GREEN,  B_GREEN:  cmp_val = CW'(GREEN_MIN - 1);
      A_YELLOW, B_YELLOW: cmp_val = CW'(YELLOW_T - 1);
      ALLRED:             cmp_val = CW'(ALLRED_T - 1);
      WALK:               cmp_val = CW'(WALK_T - 1);
      default:            cmp_val = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    case (state_q)
      A_GREEN: begin
        if (cmp_ge && (ped_pend_q || (tb && !ta) || (tb && at_max))) begin
          state_d = A_YELLOW;
        end
      end
      B_GREEN: begin
        if (cmp_ge && (ped_pend_q || (ta && !tb) || (ta && at_max))) begin
          state_d = B_YELLOW;
        end
      end
      A_YELLOW: begin
        if (cmp_eq) begin
          state_d    = ALLRED;
          last_dir_d = DIR_A;
        end
      end
      B_YELLOW: begin
        if (cmp_eq) begin
          state_d    = ALLRED;
          last_dir_d = DIR_B;
        end
      end
      ALLRED: begin
        if (cmp_eq) begin
          if (ped_pend_q) begin
            state_d = WALK;
          end else if (last_dir_q == DIR_A) begin
            state_d = B_GREEN;
          end else begin
            state_d = A_GREEN;
          end
        end
      end
      WALK: begin
        if (cmp_eq) begin
          state_d = (last_dir_q == DIR_A) ? B_GREEN : A_GREEN;
        end
      end
      default: state_d = A_GREEN;
    endcase
  end

  assign state_chg = (state_d != state_q);

  // Entering WALK clears the request even if the button is still pressed.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (state_d == WALK && state_q != WALK) begin
      ped_pend_d = 1'b0;
    end else if (ped_req && state_q != WALK) begin
      ped_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= A_GREEN;
      last_dir_q <= DIR_A;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  tlc_phase_timer #(
    .MAX_CNT (GREEN_MAX)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_chg),
    .cmp_val (cmp_val),
    .cnt_o   (cnt),
    .cmp_eq  (cmp_eq),
    .cmp_ge  (cmp_ge),
    .at_max  (at_max)
  );

  assign {ra, ya, ga, rb, yb, gb, walk} = lamps_of(state_q);
  assign ped_pend = ped_pend_q;
  assign phase    = state_q;

endmodule

// File: doc/tlc_phase_scheduler.md
Name: tlc_phase_scheduler

Overview:
Timed phase scheduler for a two-road intersection (road A, road B) with a pedestrian walk phase.
- Sequences the six lamp outputs through green, yellow and all-red phases with min/max green timers driven by the road sensors ta/tb.
- Latches pedestrian requests and inserts an all-stop WALK phase at the next all-red boundary.
- Sits directly in front of the lamp drivers and replaces the untimed sensor-only sequencing.

Parameters:
GREEN_MIN, 4, minimum green length in clk cycles (>=1)
GREEN_MAX, 10, green length after which a waiting cross-road forces a change (>GREEN_MIN)
YELLOW_T, 2, yellow length in cycles (>=1)
ALLRED_T, 1, all-red clearance length in cycles (>=1)
WALK_T, 3, pedestrian walk length in cycles (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
ta  in  1  traffic present on road A
tb  in  1  traffic present on road B
ped_req  in  1  pedestrian button, level or pulse; sampled every cycle
ra, ya, ga  out  1 each  road A red/yellow/green lamps
rb, yb, gb  out  1 each  road B red/yellow/green lamps
walk  out  1  pedestrian walk lamp
ped_pend  out  1  pedestrian request latched, not yet served
phase  out  3  current state encoding (debug/visibility)

Behaviour:
- One clock domain. Synchronous active-high reset.
- Reset values: state=A_GREEN, cnt=0, last_dir=A, ped_pend=0. Outputs ga=1, rb=1, all other lamps 0, walk=0, phase=A_GREEN.
- Lamp outputs, walk and phase are a pure decode of the state register. There is no combinational path from any input to any output.
- Exactly one lamp per road is on in every state.
- cnt: state-duration counter. Cleared to 0 on every state change, else increments, saturating at GREEN_MAX-1. Width = clog2(GREEN_MAX).
- States and lamps:
  - A_GREEN (ga, rb)
  - A_YELLOW (ya, rb)
  - ALLRED (ra, rb)
  - B_GREEN (ra, gb)
  - B_YELLOW (ra, yb)
  - WALK (ra, rb, walk)
- A_GREEN -> A_YELLOW at the end of a cycle where cnt>=GREEN_MIN-1 and any of the following holds:
  - ped_pend=1, or
  - tb=1 and ta=0, or
  - tb=1 and cnt>=GREEN_MAX-1.
  Otherwise stay. With tb=0 and no pedestrian, A_GREEN holds indefinitely.
- B_GREEN -> B_YELLOW: same rule with ta and tb swapped.
- A_YELLOW -> ALLRED when cnt=YELLOW_T-1; set last_dir=A. B_YELLOW -> ALLRED likewise; set last_dir=B.
- ALLRED when cnt=ALLRED_T-1:
  - if ped_pend=1 -> WALK;
  - else if last_dir=A -> B_GREEN;
  - else -> A_GREEN.
- WALK when cnt=WALK_T-1: last_dir=A -> B_GREEN, last_dir=B -> A_GREEN. The cross road is always served after a walk.
- ped_pend:
  - Set in any cycle with ped_req=1 while state!=WALK.
  - Cleared on the cycle WALK is entered. Clear wins over a simultaneous set.
  - ped_req during WALK is ignored.
- ped_req in ALLRED on the transition cycle is not seen by that transition. ped_pend updates the same edge, so the request is served at the next all-red.
- rst asserted mid-phase (including mid-yellow or WALK) returns to the reset state on the next edge. No yellow is inserted.

Decomposition:
- tlc_pkg: state enum (A_GREEN, A_YELLOW, ALLRED, B_GREEN, B_YELLOW, WALK with fixed 3-bit codes), dir constants (DIR_A, DIR_B), lamp-vector constants per state.
- One sub-module, tlc_phase_timer: the saturating cnt with clear input, width derived from GREEN_MAX. It exports a compare-equal output and a compare-greater-or-equal output.
- Next-state logic, ped_pend and output decode stay in the top module.

Test Plan:
1. Reset, then ta=0, tb=1 constant -> A_GREEN cycles 0-3; A_YELLOW cycles 4-5; ALLRED cycle 6; B_GREEN from cycle 7 and held, since ta=0.
2. ta=1, tb=1 constant from reset -> A_GREEN lasts 10 cycles (cnt reaches GREEN_MAX-1), then 2 yellow, 1 all-red. B_GREEN lasts 10 cycles, then returns to A. Period = 26 cycles.
3. ta=1, tb=0, ped_req 1-cycle pulse at cycle 1 -> ped_pend=1 at cycle 2; A_GREEN exits after cycle 3, yellow 4-5, ALLRED 6. WALK cycles 7-9 with walk=1, ra=rb=1, ped_pend=0 from cycle 7. B_GREEN at cycle 10.
4. ped_req held high through WALK -> ped_pend stays 0 during WALK. It re-sets on the first B_GREEN cycle, and a second WALK follows the next all-red.
5. Assert rst for 1 cycle during A_YELLOW -> next cycle ga=1, rb=1, cnt=0, ped_pend=0, no yellow on B.
6. Every cycle of every scenario -> exactly one lamp per road is on, and never ga&gb, ga&yb or ya&gb.
